// File: rtl/uart_recv.sv
// 8N1 UART receiver, 16x oversampled with 2-of-3 vote; strobe lands 2+154*TICK_CNT clocks after rxd is first sampled low.
// No backpressure: uart_data holds until the next good frame; the consumer must take it within one frame time.
module uart_recv #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       uart_frame_err,
  output logic       uart_rx_busy
);

  localparam int TICK_CNT = CLK_FREQ / (UART_BPS * 16);
  localparam int TW = (TICK_CNT > 2) ? $clog2(TICK_CNT) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CNT - 1);

  if (TICK_CNT < 2) begin : g_tick_check
    $error("uart_recv: CLK_FREQ/(UART_BPS*16) must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            s1_q, s2_q, s3_q;
  logic [1:0]      flush_q, flush_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [3:0]      smp_q, smp_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            v7_q, v7_d, v8_q, v8_d;
  logic [7:0]      data_q, data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic            fall;
  logic            tick;
  logic            vote;

  // Edges only count once s3 holds a real line value, so a line that is
  // already low when reset lifts cannot masquerade as a start edge.
  assign fall = (flush_q == 2'd3) && !s2_q && s3_q;
  assign tick = (tick_q == TICK_MAX);
  assign vote = (v7_q & v8_q) | (v7_q & s2_q) | (v8_q & s2_q);

  always_comb begin
    state_d = state_q;
    flush_d = (flush_q == 2'd3) ? 2'd3 : flush_q + 2'd1;
    tick_d  = '0;
    smp_d   = smp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    v7_d    = v7_q;
    v8_d    = v8_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;

    if (state_q != IDLE) begin
      tick_d = tick ? '0 : tick_q + TW'(1);
      if (tick) begin
        smp_d = smp_q + 4'd1;
        if (smp_q == 4'd7) v7_d = s2_q;
        if (smp_q == 4'd8) v8_d = s2_q;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          busy_d  = 1'b1;
          smp_d   = 4'd0;
          tick_d  = '0;
        end
      end
      START: begin
        if (tick && smp_q == 4'd9 && vote) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (tick && smp_q == 4'd15) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (tick && smp_q == 4'd9) shift_d = {vote, shift_q[7:1]};
        if (tick && smp_q == 4'd15) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so half a bit remains to catch the next start edge.
        if (tick && smp_q == 4'd9) begin
          if (vote) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
      flush_q <= 2'd0;
      state_q <= IDLE;
      tick_q  <= '0;
      smp_q   <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      v7_q    <= 1'b0;
      v8_q    <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= uart_rxd;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      flush_q <= flush_d;
      state_q <= state_d;
      tick_q  <= tick_d;
      smp_q   <= smp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      v7_q    <= v7_d;
      v8_q    <= v8_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign uart_data      = data_q;
  assign uart_done      = done_q;
  assign uart_frame_err = err_q;
  assign uart_rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_recv.sv
// Bench for uart_recv: frames are generated per clock from bit-time arithmetic and
// the expected strobe cycle/value comes from the frame start and the sent byte.
module tb_uart_recv;

  localparam int CLK_FREQ = 1600000;
  localparam int UART_BPS = 10000;
  localparam int TICK     = CLK_FREQ / (UART_BPS * 16);
  localparam int LAT      = 2 + 154 * TICK;
  localparam int NOM      = (CLK_FREQ / UART_BPS) * 1000;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic [7:0] uart_data;
  logic       uart_done;
  logic       uart_frame_err;
  logic       uart_rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic       done;
    logic       err;
    logic [7:0] data;
  } ev_t;

  ev_t  evq[$];
  logic busy_hist [65536];

  uart_recv #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .uart_rxd      (uart_rxd),
    .uart_data     (uart_data),
    .uart_done     (uart_done),
    .uart_frame_err(uart_frame_err),
    .uart_rx_busy  (uart_rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (cyc < 65536) busy_hist[cyc] = uart_rx_busy;
    if (uart_done || uart_frame_err) begin
      evq.push_back('{cyc, uart_done, uart_frame_err, uart_data});
      checks++;
      if (uart_done && uart_frame_err) begin
        errors++;
        $display("FAIL strobe_exclusive at cycle %0d got done=1 err=1 want at most one", cyc);
      end
    end
  end

  initial begin
    repeat (60000) @(posedge sys_clk);
    $display("FAIL watchdog cycle budget expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Drives one 8N1 frame, one clock at a time; bit index comes from elapsed
  // time over the bit period (in thousandths of a clock) so baud error is exact.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int per_m,
                            input int glitch_bit, input int abort_at, input bit hold_low,
                            output int n);
    int   total;
    int   bi;
    logic lvl;
    total = (10 * per_m) / 1000;
    n = cyc + 1;
    for (int i = 0; i < total; i++) begin
      if (i == abort_at) begin
        sys_rst  = 1'b1;
        uart_rxd = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        return;
      end
      bi = (i * 1000) / per_m;
      if (bi == 0)      lvl = 1'b0;
      else if (bi <= 8) lvl = b[bi-1];
      else              lvl = stop_ok;
      if (glitch_bit >= 0 && i >= glitch_bit * 160 + 85 && i < glitch_bit * 160 + 95) lvl = ~lvl;
      uart_rxd = lvl;
      @(posedge sys_clk);
      #1;
    end
    if (!hold_low) uart_rxd = 1'b1;
  endtask

  function automatic ev_t get_ev(input int idx);
    ev_t e;
    e.cyc = -1; e.done = 1'bx; e.err = 1'bx; e.data = 8'hxx;
    if (idx < evq.size()) e = evq[idx];
    return e;
  endfunction

  function automatic int busy_count(input int a, input int b);
    int c = 0;
    for (int i = a; i < b; i++) if (busy_hist[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic test_reset();
    uart_rxd = 1'b0;
    sys_rst  = 1'b1;
    idle(3);
    checks++; if (uart_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", uart_data); end
    checks++; if (uart_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", uart_done); end
    checks++; if (uart_frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", uart_frame_err); end
    checks++; if (uart_rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", uart_rx_busy); end
    sys_rst = 1'b0;
    idle(300);
    checks++; if (busy_count(cyc - 299, cyc + 1) != 0) begin errors++; $display("FAIL low_line_after_reset busy cycles got %0d want 0", busy_count(cyc - 299, cyc + 1)); end
    checks++; if (evq.size() != 0) begin errors++; $display("FAIL low_line_after_reset strobes got %0d want 0", evq.size()); end
    uart_rxd = 1'b1;
    idle(50);
  endtask

  task automatic test_single();
    int  n;
    ev_t e;
    evq.delete();
    send_frame(8'hA5, 1'b1, NOM, -1, -1, 1'b0, n);
    idle(200);
    e = get_ev(0);
    checks++; if (evq.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", evq.size()); end
    checks++; if (e.cyc != n + LAT) begin errors++; $display("FAIL single_time got %0d want %0d", e.cyc, n + LAT); end
    checks++; if ({e.done, e.err} !== 2'b10) begin errors++; $display("FAIL single_kind got %b%b want 10", e.done, e.err); end
    checks++; if (e.data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", e.data); end
    checks++; if (busy_hist[n+1] !== 1'b0) begin errors++; $display("FAIL busy_before got %b want 0", busy_hist[n+1]); end
    checks++; if (busy_hist[n+2] !== 1'b1) begin errors++; $display("FAIL busy_rise got %b want 1", busy_hist[n+2]); end
    checks++; if (busy_hist[n+LAT] !== 1'b0) begin errors++; $display("FAIL busy_fall got %b want 0", busy_hist[n+LAT]); end
    checks++; if (busy_count(n, n + 1700) != LAT - 2) begin errors++; $display("FAIL busy_len got %0d want %0d", busy_count(n, n + 1700), LAT - 2); end
    checks++; if (uart_data !== 8'hA5) begin errors++; $display("FAIL single_hold got %h want a5", uart_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int         ns [3];
    ev_t        e;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A;
    evq.delete();
    for (int k = 0; k < 3; k++) send_frame(bytes[k], 1'b1, NOM, -1, -1, 1'b0, ns[k]);
    idle(200);
    checks++; if (evq.size() != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", evq.size()); end
    for (int k = 0; k < 3; k++) begin
      e = get_ev(k);
      checks++; if (e.cyc != ns[k] + LAT) begin errors++; $display("FAIL b2b_time[%0d] got %0d want %0d", k, e.cyc, ns[k] + LAT); end
      checks++; if ({e.done, e.err} !== 2'b10 || e.data !== bytes[k]) begin errors++; $display("FAIL b2b_data[%0d] got %b%b/%h want 10/%h", k, e.done, e.err, e.data, bytes[k]); end
      if (k > 0) begin
        checks++; if (e.cyc - get_ev(k-1).cyc != 1600) begin errors++; $display("FAIL b2b_gap[%0d] got %0d want 1600", k, e.cyc - get_ev(k-1).cyc); end
      end
    end
  endtask

  task automatic test_glitch();
    int  n;
    int  n2;
    ev_t e;
    evq.delete();
    n = cyc + 1;
    uart_rxd = 1'b0;
    idle(40);
    uart_rxd = 1'b1;
    idle(200);
    checks++; if (busy_hist[n+2] !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise got %b want 1", busy_hist[n+2]); end
    checks++; if (busy_hist[n+2+10*TICK] !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall got %b want 0", busy_hist[n+2+10*TICK]); end
    checks++; if (busy_count(n, n + 240) != 10 * TICK) begin errors++; $display("FAIL glitch_busy_len got %0d want %0d", busy_count(n, n + 240), 10 * TICK); end
    checks++; if (evq.size() != 0) begin errors++; $display("FAIL glitch_strobes got %0d want 0", evq.size()); end
    send_frame(8'h3C, 1'b1, NOM, -1, -1, 1'b0, n2);
    idle(200);
    e = get_ev(0);
    checks++; if (e.cyc != n2 + LAT || {e.done, e.err} !== 2'b10 || e.data !== 8'h3C) begin errors++; $display("FAIL after_glitch got t=%0d %b%b/%h want t=%0d 10/3c", e.cyc, e.done, e.err, e.data, n2 + LAT); end
  endtask

  task automatic test_frame_err();
    int  n;
    ev_t e;
    evq.delete();
    send_frame(8'h81, 1'b0, NOM, -1, -1, 1'b1, n);
    idle(2000);
    e = get_ev(0);
    checks++; if (evq.size() != 1) begin errors++; $display("FAIL ferr_count got %0d want 1", evq.size()); end
    checks++; if (e.cyc != n + LAT || {e.done, e.err} !== 2'b01) begin errors++; $display("FAIL ferr_strobe got t=%0d %b%b want t=%0d 01", e.cyc, e.done, e.err, n + LAT); end
    checks++; if (uart_data !== 8'h3C) begin errors++; $display("FAIL ferr_data_kept got %h want 3c", uart_data); end
    checks++; if (busy_count(n + LAT, cyc) != 0) begin errors++; $display("FAIL break_busy got %0d want 0", busy_count(n + LAT, cyc)); end
    uart_rxd = 1'b1;
    idle(100);
    evq.delete();
    send_frame(8'h42, 1'b1, NOM, -1, -1, 1'b0, n);
    idle(200);
    e = get_ev(0);
    checks++; if (evq.size() != 1 || e.cyc != n + LAT || {e.done, e.err} !== 2'b10 || e.data !== 8'h42) begin errors++; $display("FAIL after_break got n=%0d t=%0d %b%b/%h want n=1 t=%0d 10/42", evq.size(), e.cyc, e.done, e.err, e.data, n + LAT); end
  endtask

  task automatic test_vote_and_baud();
    int  n;
    int  pers [3];
    logic [7:0] bytes [3];
    ev_t e;
    pers[0] = NOM; pers[1] = NOM * 103 / 100; pers[2] = NOM * 97 / 100;
    bytes[0] = 8'hF0; bytes[1] = 8'h55; bytes[2] = 8'h55;
    for (int k = 0; k < 3; k++) begin
      evq.delete();
      send_frame(bytes[k], 1'b1, pers[k], (k == 0) ? 2 : -1, -1, 1'b0, n);
      idle(200);
      e = get_ev(0);
      checks++; if (evq.size() != 1 || e.cyc != n + LAT || {e.done, e.err} !== 2'b10 || e.data !== bytes[k]) begin errors++; $display("FAIL vote_baud[%0d] got n=%0d t=%0d %b%b/%h want n=1 t=%0d 10/%h", k, evq.size(), e.cyc, e.done, e.err, e.data, n + LAT, bytes[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int  n;
    ev_t e;
    evq.delete();
    send_frame(8'h99, 1'b1, NOM, -1, 4 * 160 + 80, 1'b0, n);
    checks++; if (uart_rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", uart_rx_busy); end
    idle(200);
    checks++; if (evq.size() != 0) begin errors++; $display("FAIL midrst_strobes got %0d want 0", evq.size()); end
    checks++; if (uart_data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", uart_data); end
    send_frame(8'h66, 1'b1, NOM, -1, -1, 1'b0, n);
    idle(200);
    e = get_ev(0);
    checks++; if (evq.size() != 1 || e.cyc != n + LAT || {e.done, e.err} !== 2'b10 || e.data !== 8'h66) begin errors++; $display("FAIL after_midrst got n=%0d t=%0d %b%b/%h want n=1 t=%0d 10/66", evq.size(), e.cyc, e.done, e.err, e.data, n + LAT); end
  endtask

  // Random bytes, stop validity, gaps and baud error within +-2%; the model
  // predicts each strobe's cycle, kind and the byte the output should show.
  task automatic test_random();
    ev_t        exp_q[$];
    ev_t        e;
    ev_t        x;
    logic [7:0] last;
    logic [7:0] b;
    bit         ok;
    int         n;
    int         per;
    last = 8'h66;
    evq.delete();
    for (int k = 0; k < 8; k++) begin
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 3) != 0);
      per = NOM - 3200 + int'($urandom_range(0, 6400));
      send_frame(b, ok, per, -1, -1, 1'b0, n);
      if (ok) last = b;
      exp_q.push_back('{n + LAT, ok, !ok, last});
      idle(ok ? int'($urandom_range(0, 300)) : 20 + int'($urandom_range(0, 280)));
    end
    idle(200);
    checks++; if (evq.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", evq.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      e = get_ev(k);
      x = exp_q[k];
      checks++; if (e.cyc != x.cyc || {e.done, e.err} !== {x.done, x.err} || e.data !== x.data) begin errors++; $display("FAIL rand[%0d] got t=%0d %b%b/%h want t=%0d %b%b/%h", k, e.cyc, e.done, e.err, e.data, x.cyc, x.done, x.err, x.data); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_vote_and_baud();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
